// File: rtl/cdb_rr_arbiter.sv
// Common Data Bus arbiter: per-channel result queues feeding one
// registered {tag, data} broadcast per cycle, round-robin or fixed priority.
module cdb_rr_arbiter #(
    parameter int NUM_SRC    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int QDEPTH     = 2,
    parameter int RR_MODE    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [NUM_SRC-1:0]              src_valid,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    output logic [NUM_SRC-1:0]              src_ready,
    output logic                            cdb_valid,
    output logic [TAG_WIDTH-1:0]            cdb_tag,
    output logic [DATA_WIDTH-1:0]           cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]      cdb_src,
    output logic                            busy
);

    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    logic [EW-1:0]         mem_q  [NUM_SRC][QDEPTH];
    logic [EW-1:0]         mem_d  [NUM_SRC][QDEPTH];
    logic [PW-1:0]         wptr_q [NUM_SRC];
    logic [PW-1:0]         wptr_d [NUM_SRC];
    logic [PW-1:0]         rptr_q [NUM_SRC];
    logic [PW-1:0]         rptr_d [NUM_SRC];
    logic [CW-1:0]         cnt_q  [NUM_SRC];
    logic [CW-1:0]         cnt_d  [NUM_SRC];
    logic [SW-1:0]         rr_q, rr_d;
    logic                  cdb_valid_q, cdb_valid_d;
    logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
    logic [SW-1:0]         cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0]    req, push, pop;
    logic                  gnt_v;
    logic [SW-1:0]         gnt_idx;
    logic [EW-1:0]         head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic int wrap(input int v);
        return (v >= NUM_SRC) ? v - NUM_SRC : v;
    endfunction

    // Ready depends only on occupancy: a full queue never pops-through.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            req[i]       = (cnt_q[i] != '0);
            src_ready[i] = reset && (cnt_q[i] < CW'(QDEPTH));
            push[i]      = src_valid[i] && src_ready[i];
        end
    end

    always_comb begin
        gnt_v   = 1'b0;
        gnt_idx = '0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (!gnt_v && req[wrap(int'(rr_q) + k)]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = SW'(wrap(int'(rr_q) + k));
                end
            end
        end else begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (req[i]) begin
                    gnt_v   = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = gnt_v && (gnt_idx == SW'(i));
        end
    end

    assign head = mem_q[gnt_idx][rptr_q[gnt_idx]];

    always_comb begin
        mem_d       = mem_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = {src_tag[i*TAG_WIDTH +: TAG_WIDTH],
                                       src_data[i*DATA_WIDTH +: DATA_WIDTH]};
                wptr_d[i] = ptr_inc(wptr_q[i]);
            end
            if (pop[i]) begin
                rptr_d[i] = ptr_inc(rptr_q[i]);
            end
            case ({push[i], pop[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
                2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (gnt_v) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = head[EW-1 -: TAG_WIDTH];
            cdb_data_d  = head[DATA_WIDTH-1:0];
            cdb_src_d   = gnt_idx;
            if (RR_MODE != 0) begin
                rr_d = gnt_idx;
            end
        end
        // Flush drops everything in flight but keeps the fairness pointer.
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wptr_d[i] = '0;
                rptr_d[i] = '0;
                cnt_d[i]  = '0;
            end
            rr_d        = rr_q;
            cdb_valid_d = 1'b0;
            cdb_tag_d   = '0;
            cdb_data_d  = cdb_data_q;
            cdb_src_d   = cdb_src_q;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q        <= SW'(NUM_SRC - 1);
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;
    assign busy      = (|req) | cdb_valid_q;

endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Parametrised Common Data Bus arbiter that replaces the fixed-count, fixed-priority CDB mux.
- Accepts results from NUM_SRC functional-unit channels (adders, multipliers, memory) via valid/ready handshakes.
- Buffers each channel in its own small queue and broadcasts one {tag, data} per cycle on a registered CDB.
- Uses round-robin or fixed-priority arbitration; back-pressures a producer only when its queue is full.

Parameters:
- NUM_SRC, 8, number of producer channels (2..16).
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 4, reservation-station tag width; tag value 0 means "no tag".
- QDEPTH, 2, entries per channel queue (power of two, >=1).
- RR_MODE, 1, 1 = round-robin grant; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous clear of all queues and the CDB register.
- src_valid  in  NUM_SRC  producer i presents a result.
- src_tag  in  NUM_SRC*TAG_WIDTH  packed tags; channel i at [i*TAG_WIDTH +: TAG_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  packed results, same packing.
- src_ready  out  NUM_SRC  channel i queue can accept.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_WIDTH  broadcast tag.
- cdb_data  out  DATA_WIDTH  broadcast data.
- cdb_src  out  $clog2(NUM_SRC)  index of the granted channel.
- busy  out  1  any queue non-empty or cdb_valid high.

Behaviour:
- Reset (reset=0, asynchronous):
  - All queues empty; rr_ptr = NUM_SRC-1, so the first round-robin grant searches from channel 0.
  - cdb_valid, cdb_tag, cdb_data, cdb_src = 0; busy = 0.
  - src_ready = 0 while reset is low; src_ready = all ones on the first cycle after release.
- Push:
  - Channel i pushes at a rising edge when src_valid[i] and src_ready[i].
  - src_ready[i] = (count[i] < QDEPTH) and reset is high. It is combinational from the count only; there is no pop-through on a full queue.
  - A valid entry carrying tag 0 is still queued and broadcast; filtering tag 0 is the producer's responsibility.
- Arbitration, each cycle:
  - Request vector = queues non-empty at the start of the cycle.
  - RR_MODE=1: grant the first requesting index scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_SRC. On a grant, rr_ptr <= granted index.
  - RR_MODE=0: grant the lowest requesting index; rr_ptr is unused.
  - The granted head is popped, and {1, tag, data, index} is registered onto the cdb_* outputs at the same edge.
  - No request: cdb_valid <= 0, cdb_tag <= 0, cdb_data holds its value, rr_ptr holds.
- Latency:
  - A result accepted at the edge ending cycle c is granted no earlier than the edge ending cycle c+1.
  - It is visible on the CDB during cycle c+2.
  - Throughput is one broadcast per cycle, aggregate across all channels.
- Each channel queue is FIFO: per-channel result order is preserved.
- Simultaneous push and pop on the same queue: allowed when not full; count is unchanged and the pointers advance modulo QDEPTH.
- Fairness (RR_MODE=1): with all channels continuously requesting, each channel is granted exactly once per NUM_SRC cycles.
- flush=1 at an edge:
  - Clears all counts and pointers, sets cdb_valid <= 0 and cdb_tag <= 0.
  - Ignores pushes in that cycle; flush wins over push and pop.
  - rr_ptr is preserved.
- busy is combinational: OR of the non-empty flags | cdb_valid.
- Reset asserted mid-operation: all queue contents are lost immediately and the outputs go to their reset values asynchronously.

Test Plan:
- Reset release, then ch3 pushes tag=5, data=0x1234 in cycle 0 -> cdb_valid=1, tag=5, data=0x1234, cdb_src=3 in cycle 2 only; busy drops in cycle 3.
- RR_MODE=1, NUM_SRC=8: all 8 channels push once in the same cycle -> grants appear in order 0,1,...,7 on 8 consecutive cycles; a second burst starting when rr_ptr=2 grants 3,4,...,7,0,1,2.
- RR_MODE=0: ch1 and ch6 each hold 2 entries -> ch1 entries broadcast first, then ch6; ch6 never advances while ch1 requests.
- QDEPTH=2, ch0 pushes tags 1,2,3 back to back while ch4 floods (RR_MODE=1) -> src_ready[0]=0 after two entries; tag 3 is accepted only after a pop; broadcast order of ch0 is 1,2,3.
- flush asserted while ch2 holds 2 entries, cdb_valid=1, and ch5 pushes in the same cycle -> next cycle cdb_valid=0, busy=0; the ch5 entry is not broadcast.
- reset pulled low asynchronously mid-burst -> cdb_valid=0 and src_ready=0 immediately; after release, no stale tags appear on the CDB.
